// File: rtl/ipmred_mask_seq.sv
// ipmred_mask_seq -- sequential IPM-RED masking unit over GF(2^8).
//
// Turns one unmasked byte S into a v-share IPM-RED encoding R and carries the
// redundant cube S^3 with it. A single pair of GF(2^8) multipliers is reused
// over v-2 accumulation cycles instead of 2*(v-2) parallel multipliers.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid (S, L1, L2, rnd)
//   in_ready   unit idle and able to accept a request
//   S          unmasked byte
//   L1         data-chain IPM vector, byte i = L1[8i+7:8i] (bytes 0/1 unused)
//   L2         cube-chain IPM vector, same layout as L1
//   rnd        v-2 fresh random bytes, byte k = r_k
//   out_valid  R / S3 hold a complete encoding
//   out_ready  consumer takes the encoding
//   R          masked shares: R0 = S ^ sum(L1[i]*r_{i-2}),
//              R1 = S^3 ^ sum(L2[i]*r_{i-2}), Ri = r_{i-2} for i >= 2
//   S3         registered S^3
//
// The random-byte port is named rnd because "rand" is a reserved word.

module ipmred_mask_seq #(
    parameter int v = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           S,
    input  logic [v*8-1:0]       L1,
    input  logic [v*8-1:0]       L2,
    input  logic [(v-2)*8-1:0]   rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [v*8-1:0]       R,
    output logic [7:0]           S3
);

    localparam int NR   = v - 2;            // number of random bytes / ACC cycles
    localparam int IDXW = $clog2(v - 1);

    generate
        if (v < 3) begin : g_bad_v
            $error("ipmred_mask_seq: v must be >= 3");
        end
    endgenerate

    // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] cube8(input logic [7:0] a);
        return gmul8(gmul8(a, a), a);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             s_q, s_d;
    logic [NR-1:0][7:0]     l1_q, l1_d;
    logic [NR-1:0][7:0]     l2_q, l2_d;
    logic [NR-1:0][7:0]     rnd_q, rnd_d;
    logic [7:0]             acc1_q, acc1_d;
    logic [7:0]             acc2_q, acc2_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [v-1:0][7:0]      r_q, r_d;
    logic [7:0]             s3_q, s3_d;

    // Bytes 0/1 of L1/L2 never enter the computation.
    logic unused_lo;
    assign unused_lo = ^{L1[15:0], L2[15:0]};

    // Operand select for the shared multiplier pair.
    logic [7:0] l1_sel, l2_sel, r_sel;
    always_comb begin
        l1_sel = 8'h00;
        l2_sel = 8'h00;
        r_sel  = 8'h00;
        for (int k = 0; k < NR; k++) begin
            if (idx_q == IDXW'(k)) begin
                l1_sel = l1_q[k];
                l2_sel = l2_q[k];
                r_sel  = rnd_q[k];
            end
        end
    end

    logic [7:0] acc1_nxt, acc2_nxt, s3_calc;
    assign acc1_nxt = acc1_q ^ gmul8(l1_sel, r_sel);
    assign acc2_nxt = acc2_q ^ gmul8(l2_sel, r_sel);
    assign s3_calc  = cube8(s_q);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        rnd_d   = rnd_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        idx_d   = idx_q;
        r_d     = r_q;
        s3_d    = s3_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ACC;
                    s_d     = S;
                    l1_d    = L1[v*8-1:16];
                    l2_d    = L2[v*8-1:16];
                    rnd_d   = rnd;
                    acc1_d  = 8'h00;
                    acc2_d  = 8'h00;
                    idx_d   = '0;
                end
            end
            ST_ACC: begin
                acc1_d = acc1_nxt;
                acc2_d = acc2_nxt;
                idx_d  = idx_q + IDXW'(1);
                // Last term: publish straight from the updated sums so the
                // output lands on the same edge as the final accumulation.
                if (idx_q == IDXW'(v - 3)) begin
                    state_d    = ST_DONE;
                    r_d[0]     = s_q ^ acc1_nxt;
                    r_d[1]     = s3_calc ^ acc2_nxt;
                    r_d[v-1:2] = rnd_q;
                    s3_d       = s3_calc;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    // Scrub share material on the way back to idle; R/S3 keep
                    // their value, out_valid alone qualifies them.
                    state_d = ST_IDLE;
                    s_d     = 8'h00;
                    l1_d    = '0;
                    l2_d    = '0;
                    rnd_d   = '0;
                    acc1_d  = 8'h00;
                    acc2_d  = 8'h00;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= 8'h00;
            l1_q    <= '0;
            l2_q    <= '0;
            rnd_q   <= '0;
            acc1_q  <= 8'h00;
            acc2_q  <= 8'h00;
            idx_q   <= '0;
            r_q     <= '0;
            s3_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            rnd_q   <= rnd_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            idx_q   <= idx_d;
            r_q     <= r_d;
            s3_q    <= s3_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign R         = r_q;
    assign S3        = s3_q;

endmodule

// File: doc/ipmred_mask_seq.md
# ipmred_mask_seq

Sequential, handshaked IPM-RED masking unit for GF(2^8) data with a parametrised share count `v`. It converts one unmasked byte `S` into a `v`-share IPM-RED encoding and carries its redundant cube `S^3` alongside it. The share layout is bit-identical to the combinational IPM-RED mask. Instead of `2*(v-2)` parallel multipliers, one `gmul8` pair is time-shared over `v-2` accumulation cycles. It sits at the input of the masked datapath, between the plaintext/key loader and the IPM-RED arithmetic pipeline.

## Interface
- `v`, default 3: number of shares; legal range is `v >= 3`, and elaboration fails otherwise.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  request carries a valid `S`/`L1`/`L2`/`rand`.
- `in_ready`  output  1  unit accepts a request this cycle.
- `S`  input  8  unmasked byte.
- `L1`  input  `v*8`  public IPM vector for the data share chain; byte `i` is `L1[8i+7:8i]`.
- `L2`  input  `v*8`  public IPM vector for the redundant (cube) chain.
- `rand`  input  `(v-2)*8`  fresh random bytes; byte `k` is `r_k`.
- `out_valid`  output  1  `R`/`S3` hold a complete encoding.
- `out_ready`  input  1  consumer takes the encoding.
- `R`  output  `v*8`  masked shares.
- `S3`  output  8  `S^3`, registered copy.

## Operation
- The state machine has three states.
  - IDLE: `in_ready=1`.
  - ACC: accumulating.
  - DONE: `out_valid=1`.
- IDLE to ACC happens on `in_valid && in_ready`. On that edge the unit:
  - latches `S`, `L1[v*8-1:16]`, `L2[v*8-1:16]` and `rand`;
  - clears `acc1` and `acc2`;
  - sets `idx=0`.
- Bytes 0 and 1 of `L1`/`L2` are ignored.
- `S3` is computed with `cube8` from the latched `S`.
- Each ACC cycle performs:
  - `acc1 ^= gmul8(L1[idx+2], r_idx)`;
  - `acc2 ^= gmul8(L2[idx+2], r_idx)`;
  - `idx++`.
- The `idx` counter is `$clog2(v-1)` bits wide and wraps to 0 only via IDLE.
- ACC to DONE happens on the edge that performs the update for `idx == v-3`. On that same edge:
  - `R[7:0] <= S ^ final acc1`;
  - `R[15:8] <= S3 ^ final acc2`;
  - `R[8i+7:8i] <= r_{i-2}` for `2 <= i < v`;
  - `S3` output register is loaded.
- DONE to IDLE happens on `out_valid && out_ready`.
- All field arithmetic uses the codebase `gmul8` and `cube8` primitives. Addition is XOR, with no carries or width growth.
- `R` and `S3` are driven only from registers, never combinationally from inputs.
- `R` and `S3` keep their last value in IDLE/ACC. Only `out_valid` qualifies them.
- Latched operands and accumulators are cleared to 0 on entry to IDLE. This prevents residual share data lingering in registers.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready=1`;
  - `out_valid=0`;
  - `R=0`, `S3=0`;
  - `acc1/acc2/idx` and all latches = 0.
- Reset is asynchronous: asserting `rst_n` mid-ACC or mid-DONE aborts the transaction immediately. No partial output is ever flagged valid.
- Latency: `out_valid` rises `v-2` cycles after the accepting edge (1 cycle for `v=3`).
- Throughput: one encoding per `v` cycles under continuous `out_ready`, made up of:
  - 1 accept;
  - `v-2` ACC;
  - 1 DONE handshake.
- Backpressure: in DONE with `out_ready=0`, `R`, `S3` and `out_valid` are held indefinitely.
- `in_ready=0` in ACC and DONE.
- `in_valid` outside IDLE is ignored. The requester must hold it until `in_ready`.
- `in_valid` and `out_ready` may both be high in DONE: only the output handshake completes that cycle, and a new request is accepted in IDLE on the following cycle.
- Inputs are sampled only on the accepting edge. Changes to `S`, `L1`, `L2` or `rand` during ACC/DONE have no effect.

## Test plan
- Case `v=3`, zero randomness:
  - Stimulus: `S=0x01`, `rand=0x00`, any `L1`/`L2`.
  - Response: `R={0x00,0x01,0x01}` (MSB byte first), `S3=0x01`, `out_valid` 1 cycle after accept.
- Case `v=3`, identity multiplier:
  - Stimulus: `L1[2]=L2[2]=0x01`, `rand=0x5A`, `S=0x00`.
  - Response: `R={0x5A,0x5A,0x5A}`, `S3=0x00`.
- Case `v=5`, multi-cycle accumulation:
  - Stimulus: `L1[4:2]=L2[4:2]=0x01`, `rand={0x04,0x02,0x01}`, `S=0x02`.
  - Response: `S3=0x08`, `R={0x04,0x02,0x01,0x0F,0x05}`, `out_valid` exactly 3 cycles after accept.
- Backpressure:
  - Stimulus: hold `out_ready=0` for 5 cycles in DONE while toggling `in_valid` and changing `S`.
  - Response: `R`/`S3` stable, `in_ready=0`, no second accept. Release gives a single output handshake, then `in_ready=1` on the next cycle.
- Reset mid-ACC:
  - Stimulus: `v=5`, assert `rst_n=0` one cycle after accept.
  - Response: `out_valid=0`, `R=0`, `S3=0` immediately. After release, the third scenario run again produces its exact expected values.
- Back-to-back traffic:
  - Stimulus: 100 random transactions with random `in_valid`/`out_ready` gaps.
  - Response: every `R` matches the combinational IPM-RED mask model for the same inputs, with no drops or duplicates.
